// File: rtl/cut_vector_sequencer.sv
//-----------------------------------------------------------------------------
// cut_vector_sequencer
//
// Hardware test loop for a combinational circuit-under-test (CUT). For each
// vector it reads a stimulus word from a synchronous vector memory, applies
// it to the CUT through a register, waits SETTLE cycles, captures the CUT
// response and offers it on a valid/ready result stream.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_start             one-cycle run request, honoured only when idle
//   i_abort             synchronous cancel of a running sequence
//   i_num_tests         vectors to run, sampled with an accepted start
//   o_vec_rd_en         vector memory read strobe (one cycle per vector)
//   o_vec_addr          vector memory address
//   i_vec_rdata         vector memory data, valid one cycle after the strobe
//   o_cut_in            registered CUT stimulus
//   i_cut_out           CUT response
//   o_res_valid         result beat valid
//   i_res_ready         downstream accept
//   o_res_data          captured CUT response
//   o_res_index         vector index of the beat
//   o_res_last          final beat of the run
//   o_busy              high whenever the sequencer is not idle
//   o_done              one-cycle pulse on normal completion
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module cut_vector_sequencer #(
  parameter int IN_W   = 41,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 14,
  parameter int SETTLE = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W:0]   i_num_tests,
  output logic              o_vec_rd_en,
  output logic [ADDR_W-1:0] o_vec_addr,
  input  logic [IN_W-1:0]   i_vec_rdata,
  output logic [IN_W-1:0]   o_cut_in,
  input  logic [OUT_W-1:0]  i_cut_out,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [OUT_W-1:0]  o_res_data,
  output logic [ADDR_W-1:0] o_res_index,
  output logic              o_res_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_EMIT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Settle counter runs 0..SETTLE-1; it keeps one bit even when unused.
  localparam int                SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [SET_W-1:0]  SET_ONE  = SET_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  state_t              r_state,     w_state;
  logic [ADDR_W-1:0]   r_idx,       w_idx;
  logic [ADDR_W:0]     r_count,     w_count;
  logic [SET_W-1:0]    r_set_cnt,   w_set_cnt;
  logic                r_vec_rd_en, w_vec_rd_en;
  logic [ADDR_W-1:0]   r_vec_addr,  w_vec_addr;
  logic [IN_W-1:0]     r_cut_in,    w_cut_in;
  logic                r_res_valid, w_res_valid;
  logic [OUT_W-1:0]    r_res_data,  w_res_data;
  logic [ADDR_W-1:0]   r_res_index, w_res_index;
  logic                r_res_last,  w_res_last;
  logic                r_busy,      w_busy;
  logic                r_done,      w_done;
  logic                w_handshake;

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_count     = r_count;
    w_set_cnt   = r_set_cnt;
    w_cut_in    = r_cut_in;
    w_res_valid = r_res_valid;
    w_res_data  = r_res_data;
    w_res_index = r_res_index;
    w_res_last  = r_res_last;
    w_handshake = r_res_valid & i_res_ready;

    if (i_abort && (r_state != S_IDLE)) begin
      // Cancel wins over everything; the applied stimulus is left in place.
      w_state     = S_IDLE;
      w_res_valid = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_num_tests == '0) begin
              w_state = S_DONE;
            end else begin
              w_count = (i_num_tests > DEPTH_C) ? DEPTH_C : i_num_tests;
              w_idx   = '0;
              w_state = S_FETCH;
            end
          end else begin
            w_state = S_IDLE;
          end
        end
        S_FETCH: begin
          w_state = S_LOAD;
        end
        S_LOAD: begin
          // Memory data arrives in this cycle (one cycle after the strobe).
          w_cut_in  = i_vec_rdata;
          w_set_cnt = '0;
          if (SETTLE == 0) begin
            w_state = S_CAPTURE;
          end else begin
            w_state = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            w_state = S_CAPTURE;
          end else begin
            w_set_cnt = r_set_cnt + SET_ONE;
          end
        end
        S_CAPTURE: begin
          w_res_data  = i_cut_out;
          w_res_index = r_idx;
          w_res_last  = ({1'b0, r_idx} == (r_count - CNT_ONE));
          w_res_valid = 1'b1;
          w_state     = S_EMIT;
        end
        S_EMIT: begin
          if (w_handshake) begin
            w_res_valid = 1'b0;
            if (r_res_last) begin
              w_state = S_DONE;
            end else begin
              w_idx   = r_idx + IDX_ONE;
              w_state = S_FETCH;
            end
          end else begin
            w_state = S_EMIT;
          end
        end
        S_DONE: begin
          w_state = S_IDLE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end

    // Strobe-type outputs are registered from the state being entered so
    // they line up with that state's cycle.
    w_vec_rd_en = (w_state == S_FETCH);
    w_vec_addr  = w_vec_rd_en ? w_idx : '0;
    w_busy      = (w_state != S_IDLE);
    w_done      = (w_state == S_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_count     <= '0;
      r_set_cnt   <= '0;
      r_vec_rd_en <= 1'b0;
      r_vec_addr  <= '0;
      r_cut_in    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_index <= '0;
      r_res_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_count     <= w_count;
      r_set_cnt   <= w_set_cnt;
      r_vec_rd_en <= w_vec_rd_en;
      r_vec_addr  <= w_vec_addr;
      r_cut_in    <= w_cut_in;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
      r_res_index <= w_res_index;
      r_res_last  <= w_res_last;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign o_vec_rd_en = r_vec_rd_en;
  assign o_vec_addr  = r_vec_addr;
  assign o_cut_in    = r_cut_in;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_index = r_res_index;
  assign o_res_last  = r_res_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
